// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl: write-domain pointer and status block for an asynchronous FIFO.
//
// It keeps the binary write counter and the gray write pointer. It converts the
// synchronised gray read pointer back to binary. From those it registers the
// occupancy level, full and almost-full flags. Build with WPTR_FULL_OVF_EN defined
// to add a sticky overflow flag; otherwise wovf is tied to 0.
//
// Parameters:
//   ADDRSIZE     RAM address width; DEPTH = 2**ADDRSIZE (>= 2)
//   AFULL_MARGIN wafull asserts when free slots <= AFULL_MARGIN (0..DEPTH-1)
//
// Ports:
//   wclk      in   write-domain clock (rising edge)
//   wrst      in   asynchronous active-high reset
//   winc      in   write request
//   wq2_rptr  in   gray read pointer, already synchronised into wclk
//   waddr     out  binary RAM write address
//   wptr      out  gray write pointer to the read-side synchroniser
//   wfull     out  FIFO full (registered)
//   wafull    out  almost full (registered)
//   wlevel    out  occupied entries 0..DEPTH (registered)
//   wovf      out  sticky overflow flag (0 when compiled out)
module wptr_full_lvl #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int unsigned PW    = ADDRSIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam logic [PW-1:0] FULL_LVL  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_MARGIN);

    logic [PW-1:0] wbin_q,   wbin_d;
    logic [PW-1:0] wptr_q,   wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic [PW-1:0] rbin;
    logic [PW-1:0] lvlnext;
    logic          accept;

    // Gray-to-binary of the synchronised read pointer: XOR prefix from the MSB down.
    always_comb begin
        rbin         = '0;
        rbin[PW-1]   = wq2_rptr[PW-1];
        for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Next write counter, gray pointer and status. The level is taken after this
    // cycle's write so the registered flags already account for it.
    always_comb begin
        accept   = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(accept);
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        lvlnext  = wbin_d - rbin;
        wlevel_d = lvlnext;
        wfull_d  = (lvlnext == FULL_LVL);
        wafull_d = (lvlnext >= AFULL_LVL);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wptr_q;
    assign wlevel = wlevel_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;

`ifdef WPTR_FULL_OVF_EN
    logic wovf_q, wovf_d;

    // Sticky: any write attempted while full latches until reset.
    always_comb begin
        wovf_d = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
        end
    end

    assign wovf = wovf_q;
`else
    assign wovf = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Testbench for wptr_full_lvl (ADDRSIZE=4, AFULL_MARGIN=2).
// The read pointer is driven as a binary count and presented to the DUT in gray.
// A count-based model (accepted writes vs. read count) predicts every output.
module tb_wptr_full_lvl;

    localparam int unsigned AS = 4;
`ifdef WPTR_FULL_OVF_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic [AS:0]   rb;
    logic [AS:0]   wq2_rptr;
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AS:0]   wlevel;
    logic          wovf;

    int checks   = 0;
    int failures = 0;

    assign wq2_rptr = rb ^ (rb >> 1);

    wptr_full_lvl #(.ADDRSIZE(AS), .AFULL_MARGIN(2)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: total accepted writes (mod 32) minus read count gives the level.
    int m_cnt, m_lvl, m_ovf;

    always @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            m_cnt = 0;
            m_lvl = 0;
            m_ovf = 0;
        end else begin
            if (winc && m_lvl == 16) begin
                m_ovf = OVF_EN;
            end else if (winc) begin
                m_cnt = (m_cnt + 1) % 32;
            end
            m_lvl = (m_cnt - int'(rb) + 32) % 32;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge wclk) begin
        if (!wrst) begin
            chk("m_waddr",  int'(waddr),  m_cnt % 16);
            chk("m_wptr",   int'(wptr),   m_cnt ^ (m_cnt >> 1));
            chk("m_wlevel", int'(wlevel), m_lvl);
            chk("m_wfull",  int'(wfull),  int'(m_lvl == 16));
            chk("m_wafull", int'(wafull), int'(m_lvl >= 14));
            chk("m_wovf",   int'(wovf),   m_ovf);
        end
    end

    task automatic cycle(input logic w, input logic [AS:0] r);
        winc = w;
        rb   = r;
        @(posedge wclk);
        #1;
    endtask

    logic [AS:0] h0, h1, wc;
    bit seen31, seen32;

    initial begin
        wrst = 1'b1;
        winc = 1'b0;
        rb   = '0;
        repeat (2) @(posedge wclk);
        #1 wrst = 1'b0;

        // 1: asynchronous reset mid-cycle after 5 writes
        repeat (5) cycle(1'b1, 5'd0);
        chk("pre_rst_waddr", int'(waddr), 5);
        #2 wrst = 1'b1;
        winc = 1'b0;
        #1;
        chk("rst_waddr",  int'(waddr),  0);
        chk("rst_wptr",   int'(wptr),   0);
        chk("rst_wlevel", int'(wlevel), 0);
        chk("rst_flags",  int'({wfull, wafull, wovf}), 0);
        @(posedge wclk);
        #1 wrst = 1'b0;

        // 2: 16 back-to-back writes with read pointer at 0
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 5'd0);
            chk("fill_wlevel", int'(wlevel), i);
            chk("fill_wafull", int'(wafull), int'(i >= 14));
            chk("fill_wfull",  int'(wfull),  int'(i == 16));
        end
        chk("fill_wptr",  int'(wptr),  int'(5'b11000));
        chk("fill_waddr", int'(waddr), 0);

        // 3: writes while full are dropped
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd0);
            chk("blk_wptr",   int'(wptr),   int'(5'b11000));
            chk("blk_wlevel", int'(wlevel), 16);
            chk("blk_wovf",   int'(wovf),   OVF_EN);
        end

        // 4: read pointer advances to 4
        cycle(1'b0, 5'd4);
        chk("rd4_wlevel", int'(wlevel), 12);
        chk("rd4_wfull",  int'(wfull),  0);
        chk("rd4_wafull", int'(wafull), 0);

        // 5: 40 writes, read pointer trailing two cycles
        cycle(1'b0, 5'd16);
        chk("empty_wlevel", int'(wlevel), 0);
        wc = 5'd16;
        h0 = 5'd16;
        h1 = 5'd16;
        seen31 = 1'b0;
        seen32 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, h1);
            h1 = h0;
            wc = wc + 5'd1;
            h0 = wc;
            if (wptr == 5'b10000) seen31 = 1'b1;
            if (seen31 && wptr == 5'b00000) seen32 = 1'b1;
            chk("strm_lvl_le3", int'(wlevel <= 5'd3), 1);
            chk("strm_wfull",   int'(wfull), 0);
        end
        chk("strm_seen31", int'(seen31), 1);
        chk("strm_wrap32", int'(seen32), 1);
        chk("strm_wptr",   int'(wptr), int'(5'd24 ^ 5'd12));

        // 6: level 15, write and read advance together
        cycle(1'b0, 5'd9);
        chk("l15_wlevel", int'(wlevel), 15);
        cycle(1'b1, 5'd10);
        chk("sim_wlevel", int'(wlevel), 15);
        chk("sim_wafull", int'(wafull), 1);
        chk("sim_wfull",  int'(wfull),  0);

        cycle(1'b0, 5'd10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wptr_full_lvl.md
# wptr_full_lvl

Write-side pointer and status block for the asynchronous FIFO, generalising the basic gray-pointer/full generator. It keeps the binary write address and gray write pointer, and converts the synchronised read pointer back to binary. It then reports full, a parameterised almost-full flag and the occupancy level seen from the write domain, plus an optional sticky overflow flag. It sits in the write clock domain between the write-side client, the dual-port RAM and the read-pointer synchroniser.

## Interface
- `ADDRSIZE`, default 4: RAM address width; DEPTH = 2^ADDRSIZE; legal range ≥ 2.
- `AFULL_MARGIN`, default 2: `wafull` asserts when free slots ≤ AFULL_MARGIN; legal range 0..DEPTH-1.

- `wclk`  input  1  write-domain clock; all logic on its rising edge.
- `wrst`  input  1  reset, asynchronous, active-high.
- `winc`  input  1  write request.
- `wq2_rptr`  input  ADDRSIZE+1  gray read pointer, already synchronised into `wclk`.
- `waddr`  output  ADDRSIZE  RAM write address, binary.
- `wptr`  output  ADDRSIZE+1  gray write pointer, sent to the read-side synchroniser.
- `wfull`  output  1  FIFO full, registered.
- `wafull`  output  1  almost full, registered.
- `wlevel`  output  ADDRSIZE+1  occupied entries, 0..DEPTH, registered.
- `wovf`  output  1  sticky overflow flag; constant 0 when the feature is compiled out.

## Operation
- Write is accepted when `winc & ~wfull`.
- Write counter: `wbinnext = wbin + accept`, computed modulo 2^(ADDRSIZE+1).
- `waddr = wbin[ADDRSIZE-1:0]`.
- `wgraynext = (wbinnext>>1) ^ wbinnext`.
- `wptr` is registered from `wgraynext` and changes by one bit per accepted write.
- Read pointer conversion: `rbin` is the gray-to-binary form of `wq2_rptr`, using a per-bit XOR prefix from the MSB down. It is combinational.
- Level: `lvlnext = wbinnext - rbin`, computed modulo 2^(ADDRSIZE+1). It is valid whenever 0 ≤ lvlnext ≤ DEPTH.
- Registered status, updated every cycle:
  - `wlevel <= lvlnext`
  - `wfull <= (lvlnext == DEPTH)`. This is equivalent to `wgraynext` matching `wq2_rptr` with its top two bits inverted.
  - `wafull <= (lvlnext >= DEPTH-AFULL_MARGIN)`. It is asserted whenever `wfull` is asserted.
- Write when full (`winc & wfull`):
  - The write is dropped.
  - `wbin` and `wptr` hold.
  - `wovf` sets if the feature is compiled in.
- Wrap-around: `wbin` wraps from 2^(ADDRSIZE+1)-1 to 0 with no special casing, and `waddr` wraps from DEPTH-1 to 0.
- Reset (`wrst`=1, asynchronous at any time, including mid-burst):
  - `wbin`, `wptr`, `waddr` = 0
  - `wfull`, `wafull`, `wovf` = 0
  - `wlevel` = 0
- The read side must be reset together with this block. Pointer resynchronisation is outside this block.

## Timing
- Accepted write in cycle N: `waddr` and `wptr` advance at the edge ending cycle N. `wlevel`, `wfull` and `wafull` reflect that write from cycle N+1.
- A change on `wq2_rptr` in cycle N is reflected in `wlevel`, `wfull` and `wafull` from cycle N+1. The 2-flop synchroniser latency is additional and external.
- Simultaneous accepted write and read-pointer advance in the same cycle: both enter `lvlnext`, so the net level is unchanged.
- `wfull` is registered. A `winc` in the cycle after the last free slot is filled is blocked: no overrun is possible.
- Full release is pessimistic (synchroniser delay only). `wfull` never deasserts early.

## Configuration
- `WPTR_FULL_OVF_EN` defined:
  - `wovf` register present.
  - Sets at the edge of any cycle with `winc & wfull`.
  - Stays 1 until `wrst`.
- `WPTR_FULL_OVF_EN` undefined:
  - No register.
  - `wovf` tied to 0.
  - Dropped writes are silent.

## Test plan
Default configuration for all scenarios: ADDRSIZE=4 (DEPTH 16), AFULL_MARGIN=2.

1. Assert `wrst` asynchronously mid-cycle after 5 writes → immediately `waddr`=0, `wptr`=0, `wlevel`=0, `wfull`=0, `wafull`=0, `wovf`=0.
2. Hold `wq2_rptr`=0 and issue 16 back-to-back writes → `wlevel` steps 1..16. `wafull` rises the cycle after write 14 (level 14). `wfull` rises the cycle after write 16. Final `wptr`=5'b11000, `waddr`=0.
3. From full, hold `winc`=1 for 3 cycles → `wptr` stays 5'b11000 and `wlevel` stays 16. `wovf`=1 from the first blocked cycle with the macro, 0 without.
4. From full, set `wq2_rptr`=5'b00110 (binary 4) → next cycle `wlevel`=12, `wfull`=0, `wafull`=0.
5. Stream 40 writes with `wq2_rptr` following `wptr` two cycles late → `wptr` passes through 5'b10000 (binary 31) to 5'b00000 (binary 32, wraps). `wlevel` stays ≤ 3. `wfull` is never set.
6. At level 15, write and advance `wq2_rptr` by 1 in the same cycle → `wlevel` stays 15, `wafull`=1, `wfull`=0.
